// File: rtl/ysyx_2022040010_wb_stage_pkg.sv
// Shared constants for the write-back stage: load size codes, WB FSM
// state encodings and the enable/zero-word constants used across the core.
package ysyx_2022040010_wb_stage_pkg;

    localparam int unsigned WB_XLEN    = 64;
    localparam int unsigned WB_RADDR_W = 5;

    localparam logic             ENABLE    = 1'b1;
    localparam logic             DISABLE   = 1'b0;
    localparam logic [WB_XLEN-1:0] ZERO_WORD = '0;

    // Load access size as carried by the MEM bundle
    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2,
        LD_D = 2'd3
    } ld_size_e;

    // Write-back holding register state
    typedef enum logic [1:0] {
        WB_EMPTY  = 2'd0,
        WB_WAIT   = 2'd1,
        WB_COMMIT = 2'd2
    } wb_state_e;

endpackage

// File: rtl/ysyx_2022040010_wb_stage_load_ext.sv
// Load data extraction: shifts the aligned doubleword down by the byte
// offset, takes the sized field and sign- or zero-extends it.
module ysyx_2022040010_load_ext
    import ysyx_2022040010_wb_stage_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      addr_lo,
    input  logic [1:0]      size,
    input  logic            uns,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] v;

    // Shift by byte offset (zero-filled), then size/extend the low field
    always_comb begin
        v      = rdata >> {addr_lo, 3'b000};
        result = v;
        case (size)
            LD_B: result = uns ? {{(XLEN-8){1'b0}}, v[7:0]}
                               : {{(XLEN-8){v[7]}}, v[7:0]};
            LD_H: result = uns ? {{(XLEN-16){1'b0}}, v[15:0]}
                               : {{(XLEN-16){v[15]}}, v[15:0]};
            LD_W: result = uns ? {{(XLEN-32){1'b0}}, v[31:0]}
                               : {{(XLEN-32){v[31]}}, v[31:0]};
            default: result = v;
        endcase
    end

endmodule

// File: rtl/ysyx_2022040010_wb_stage.sv
// RV64 write-back stage: one-entry holding register between MEM and the
// register file, with load-data wait, retire counter and sticky ebreak halt.
// Optional feature macro: YSYX_WB_DIFFTEST_EN (adds commit_valid/commit_pc).
module ysyx_2022040010_wb_stage
    import ysyx_2022040010_wb_stage_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_valid,
    output logic               mem_ready,
    input  logic [XLEN-1:0]    mem_pc,
    input  logic               mem_rd_we,
    input  logic [RADDR_W-1:0] mem_rd_addr,
    input  logic [XLEN-1:0]    mem_alu_res,
    input  logic               mem_is_load,
    input  logic [1:0]         mem_ld_size,
    input  logic               mem_ld_uns,
    input  logic [2:0]         mem_addr_lo,
    input  logic               mem_ebreak,
    input  logic               dmem_rvalid,
    input  logic [XLEN-1:0]    dmem_rdata,
    output logic               we,
    output logic [RADDR_W-1:0] waddr,
    output logic [XLEN-1:0]    wdata,
    output logic [63:0]        instret,
`ifdef YSYX_WB_DIFFTEST_EN
    output logic               commit_valid,
    output logic [XLEN-1:0]    commit_pc,
`endif
    output logic               halt
);

    wb_state_e          state, state_nxt;
    logic               accept;

    logic               ent_rd_we;
    logic [RADDR_W-1:0] ent_rd;
    logic [XLEN-1:0]    ent_res;
    logic [1:0]         ent_size;
    logic               ent_uns;
    logic [2:0]         ent_lo;
    logic               ent_ebreak;
    logic [XLEN-1:0]    ld_ext;

    ysyx_2022040010_load_ext #(
        .XLEN (XLEN)
    ) u_load_ext (
        .rdata   (dmem_rdata),
        .addr_lo (ent_lo),
        .size    (ent_size),
        .uns     (ent_uns),
        .result  (ld_ext)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= WB_EMPTY;
        else     state <= state_nxt;
    end

    // Next state, handshake and regfile write port
    always_comb begin
        state_nxt = state;
        mem_ready = !halt && (state == WB_EMPTY || state == WB_COMMIT);
        accept    = mem_valid && mem_ready;
        we        = DISABLE;
        waddr     = '0;
        wdata     = ZERO_WORD[XLEN-1:0];
        case (state)
            WB_EMPTY: begin
                if (accept) state_nxt = mem_is_load ? WB_WAIT : WB_COMMIT;
            end
            WB_WAIT: begin
                if (dmem_rvalid) state_nxt = WB_COMMIT;
            end
            WB_COMMIT: begin
                we    = ent_rd_we && (ent_rd != '0);
                waddr = ent_rd;
                wdata = ent_res;
                if (accept) state_nxt = mem_is_load ? WB_WAIT : WB_COMMIT;
                else        state_nxt = WB_EMPTY;
            end
            default: state_nxt = WB_EMPTY;
        endcase
    end

    // Entry capture, load data latch, retire counter and halt flag.
    // ent_res first takes the ALU result and is overwritten by the
    // extended load data when the response arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_rd_we  <= 1'b0;
            ent_rd     <= '0;
            ent_res    <= '0;
            ent_size   <= '0;
            ent_uns    <= 1'b0;
            ent_lo     <= '0;
            ent_ebreak <= 1'b0;
            instret    <= '0;
            halt       <= 1'b0;
        end else begin
            if (accept) begin
                ent_rd_we  <= mem_rd_we;
                ent_rd     <= mem_rd_addr;
                ent_res    <= mem_alu_res;
                ent_size   <= mem_ld_size;
                ent_uns    <= mem_ld_uns;
                ent_lo     <= mem_addr_lo;
                ent_ebreak <= mem_ebreak;
            end else if (state == WB_WAIT && dmem_rvalid) begin
                ent_res <= ld_ext;
            end
            if (state == WB_COMMIT) begin
                instret <= instret + 64'd1;
                if (ent_ebreak) halt <= ENABLE;
            end
        end
    end

`ifdef YSYX_WB_DIFFTEST_EN
    logic [XLEN-1:0] ent_pc;

    // PC of the held entry, reported one cycle after its commit
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_pc       <= '0;
            commit_valid <= 1'b0;
            commit_pc    <= '0;
        end else begin
            if (accept) ent_pc <= mem_pc;
            commit_valid <= (state == WB_COMMIT);
            if (state == WB_COMMIT) commit_pc <= ent_pc;
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^mem_pc;
`endif

endmodule
